// File: rtl/general_defines.sv
// Shared core-wide sizes and record types for the issue path.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package general_defines;

  localparam int IQ_LENGTH      = 8;
  localparam int BYPASS_LENGTH  = 3;
  localparam int NUM_FU_TYPES   = 8;
  localparam int IQ_IDX_W       = $clog2(IQ_LENGTH);
  localparam int ROB_IDX_W      = 5;
  localparam int PHYS_REG_IDX_W = 6;
  localparam int XLEN           = 32;
  // One spare bit so illegal FU encodings can exist and be rejected.
  localparam int FU_TYPE_W      = $clog2(NUM_FU_TYPES) + 1;
  localparam int FU_IDX_W       = $clog2(NUM_FU_TYPES);

  typedef struct packed {
    logic                      valid;
    logic [ROB_IDX_W:0]        rob_idx;
    logic [FU_TYPE_W-1:0]      fu_type;
    logic [PHYS_REG_IDX_W-1:0] phys_rd;
    logic [PHYS_REG_IDX_W-1:0] phys_rs1;
    logic                      rs1_ready;
    logic [XLEN-1:0]           rs1_value;
    logic [PHYS_REG_IDX_W-1:0] phys_rs2;
    logic                      rs2_ready;
    logic [XLEN-1:0]           rs2_value;
  } iq_entry_t;

  typedef struct packed {
    logic                      valid;
    logic [PHYS_REG_IDX_W-1:0] phys_rd;
    logic [XLEN-1:0]           result;
  } bypass_entry_t;

  // Apply writeback broadcasts to one entry. Lowest port wins on multiple
  // hits; operands that are already ready keep their value.
  function automatic iq_entry_t wake_entry(input iq_entry_t e,
                                           input bypass_entry_t [BYPASS_LENGTH-1:0] bus);
    iq_entry_t r;
    logic      hit1;
    logic      hit2;
    r    = e;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int k = 0; k < BYPASS_LENGTH; k++) begin
      if (bus[k].valid && !e.rs1_ready && !hit1 && (bus[k].phys_rd == e.phys_rs1)) begin
        r.rs1_ready = 1'b1;
        r.rs1_value = bus[k].result;
        hit1        = 1'b1;
      end
      if (bus[k].valid && !e.rs2_ready && !hit2 && (bus[k].phys_rd == e.phys_rs2)) begin
        r.rs2_ready = 1'b1;
        r.rs2_value = bus[k].result;
        hit2        = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_age_select.sv
// Oldest-candidate picker: smallest (rob_idx - rob_head) wins, ties to lowest slot.
// Latency: purely combinational.
// Backpressure: none; caller masks candidates.
module iq_age_select #(
  parameter int N  = 8,
  parameter int W  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        cand_i,
  input  logic [N-1:0][W-1:0] rob_idx_i,
  input  logic [W-1:0]        rob_head_i,
  output logic [N-1:0]        grant_o,
  output logic [IW-1:0]       idx_o,
  output logic                any_o
);

  logic          found;
  logic [IW-1:0] best_idx;
  logic [W-1:0]  best_age;
  logic [W-1:0]  age;

  // Linear scan; strict less-than keeps the lower slot on equal age.
  always_comb begin
    found    = 1'b0;
    best_idx = '0;
    best_age = '0;
    age      = '0;
    for (int i = 0; i < N; i++) begin
      age = rob_idx_i[i] - rob_head_i;
      if (cand_i[i] && (!found || (age < best_age))) begin
        found    = 1'b1;
        best_idx = IW'(i);
        best_age = age;
      end
    end
    grant_o = '0;
    if (found) grant_o[best_idx] = 1'b1;
    idx_o = best_idx;
    any_o = found;
  end

endmodule

// File: rtl/issue_scheduler.sv
// Unified issue queue: wakes operands from writeback, issues oldest ready entry.
// Latency: ready-at-dispatch entry appears on issue_valid_o two cycles later.
// Backpressure: issue register holds while !issue_ready_i; disp_ready_o drops when full.
module issue_scheduler
  import general_defines::*;
(
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush_i,
  input  logic [ROB_IDX_W:0]                     rob_head_i,
  input  logic                                   disp_valid_i,
  input  iq_entry_t                              disp_entry_i,
  output logic                                   disp_ready_o,
  input  bypass_entry_t [BYPASS_LENGTH-1:0]      wb_bus_i,
  input  logic [NUM_FU_TYPES-1:0]                fu_busy_i,
  output logic                                   issue_valid_o,
  output iq_entry_t                              issue_entry_o,
  input  logic                                   issue_ready_i,
  output logic [IQ_IDX_W:0]                      count_o
);

  localparam logic [IQ_IDX_W:0] CNT_FULL = (IQ_IDX_W+1)'(IQ_LENGTH);
  localparam logic [IQ_IDX_W:0] CNT_ONE  = (IQ_IDX_W+1)'(1);

  iq_entry_t                           slots_q [IQ_LENGTH];
  iq_entry_t                           slots_d [IQ_LENGTH];
  iq_entry_t                           issue_q;
  logic                                issue_valid_q;
  logic [IQ_IDX_W:0]                   count_q;
  logic [IQ_IDX_W:0]                   count_d;
  iq_entry_t                           ins_entry;
  logic [IQ_IDX_W-1:0]                 free_idx;
  logic                                do_disp;
  logic [IQ_LENGTH-1:0]                cand;
  logic [IQ_LENGTH-1:0][ROB_IDX_W:0]   slot_rob;
  logic [IQ_LENGTH-1:0]                sel_grant;
  logic [IQ_IDX_W-1:0]                 sel_idx;
  logic                                sel_any;
  logic                                issue_load;

  // Credit is based on registered occupancy only.
  assign disp_ready_o  = (count_q < CNT_FULL);
  assign do_disp       = disp_valid_i && disp_ready_o;
  assign count_o       = count_q;
  assign issue_valid_o = issue_valid_q;
  assign issue_entry_o = issue_q;
  assign issue_load    = (!issue_valid_q || issue_ready_i) && sel_any;

  // Lowest free slot; existence is guaranteed whenever disp_ready_o is high.
  always_comb begin
    free_idx = '0;
    for (int i = IQ_LENGTH - 1; i >= 0; i--) begin
      if (!slots_q[i].valid) free_idx = IQ_IDX_W'(i);
    end
  end

  // Incoming entry sees this cycle's broadcasts so none are missed.
  always_comb begin
    ins_entry       = disp_entry_i;
    ins_entry.valid = 1'b1;
    ins_entry       = wake_entry(ins_entry, wb_bus_i);
  end

  // Candidate mask from registered state; out-of-range FU types never issue.
  always_comb begin
    cand     = '0;
    slot_rob = '0;
    for (int i = 0; i < IQ_LENGTH; i++) begin
      slot_rob[i] = slots_q[i].rob_idx;
      cand[i] = slots_q[i].valid && slots_q[i].rs1_ready && slots_q[i].rs2_ready &&
                (slots_q[i].fu_type < FU_TYPE_W'(NUM_FU_TYPES)) &&
                !fu_busy_i[slots_q[i].fu_type[FU_IDX_W-1:0]];
    end
  end

  iq_age_select #(
    .N  (IQ_LENGTH),
    .W  (ROB_IDX_W + 1),
    .IW (IQ_IDX_W)
  ) u_age_select (
    .cand_i     (cand),
    .rob_idx_i  (slot_rob),
    .rob_head_i (rob_head_i),
    .grant_o    (sel_grant),
    .idx_o      (sel_idx),
    .any_o      (sel_any)
  );

  // Next slot contents: wakeup, free on select, then write the dispatched entry.
  always_comb begin
    count_d = count_q;
    if (do_disp)    count_d = count_d + CNT_ONE;
    if (issue_load) count_d = count_d - CNT_ONE;
    for (int i = 0; i < IQ_LENGTH; i++) begin
      slots_d[i] = slots_q[i].valid ? wake_entry(slots_q[i], wb_bus_i) : slots_q[i];
      if (issue_load && sel_grant[i]) slots_d[i].valid = 1'b0;
      if (do_disp && (free_idx == IQ_IDX_W'(i))) slots_d[i] = ins_entry;
    end
  end

  // Slot storage and occupancy; reset beats flush, flush beats everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < IQ_LENGTH; i++) slots_q[i] <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < IQ_LENGTH; i++) slots_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < IQ_LENGTH; i++) slots_q[i] <= slots_d[i];
      count_q <= count_d;
    end
  end

  // Issue register: load the winner when empty or draining, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
    end else if (flush_i) begin
      issue_valid_q <= 1'b0;
    end else if (issue_load) begin
      issue_q       <= slots_q[sel_idx];
      issue_valid_q <= 1'b1;
    end else if (issue_ready_i) begin
      issue_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: expected issues queued at dispatch time.
// Latency: checks issue timing cycle by cycle around each scenario.
// Backpressure: exercises issue stall, full queue, fu busy, flush and reset.
module tb_issue_scheduler;
  import general_defines::*;

  typedef struct packed {
    logic [ROB_IDX_W:0] rob;
    logic [XLEN-1:0]    v1;
    logic [XLEN-1:0]    v2;
  } exp_t;

  logic                              clk = 1'b0;
  logic                              rst_n;
  logic                              flush;
  logic [ROB_IDX_W:0]                rob_head;
  logic                              disp_valid;
  iq_entry_t                         disp_entry;
  logic                              disp_ready;
  bypass_entry_t [BYPASS_LENGTH-1:0] wb_bus;
  logic [NUM_FU_TYPES-1:0]           fu_busy;
  logic                              issue_valid;
  iq_entry_t                         issue_entry;
  logic                              issue_ready;
  logic [IQ_IDX_W:0]                 count;

  exp_t sb[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  issue_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush),
    .rob_head_i    (rob_head),
    .disp_valid_i  (disp_valid),
    .disp_entry_i  (disp_entry),
    .disp_ready_o  (disp_ready),
    .wb_bus_i      (wb_bus),
    .fu_busy_i     (fu_busy),
    .issue_valid_o (issue_valid),
    .issue_entry_o (issue_entry),
    .issue_ready_i (issue_ready),
    .count_o       (count)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic iq_entry_t mk(input int rob, input int fu, input int t1, input bit r1,
                                   input int t2, input bit r2);
    iq_entry_t e;
    e           = '0;
    e.rob_idx   = rob[ROB_IDX_W:0];
    e.fu_type   = fu[FU_TYPE_W-1:0];
    e.phys_rd   = 6'd63;
    e.phys_rs1  = t1[PHYS_REG_IDX_W-1:0];
    e.rs1_ready = r1;
    e.rs1_value = r1 ? (32'h1000 + rob) : 32'hBAD0;
    e.phys_rs2  = t2[PHYS_REG_IDX_W-1:0];
    e.rs2_ready = r2;
    e.rs2_value = r2 ? (32'h2000 + rob) : 32'hBAD0;
    return e;
  endfunction

  task automatic push_exp(input int rob, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2);
    exp_t e;
    e.rob = rob[ROB_IDX_W:0];
    e.v1  = v1;
    e.v2  = v2;
    sb.push_back(e);
  endtask

  task automatic set_wb(input int k, input int tag, input logic [XLEN-1:0] val);
    wb_bus[k].valid   = 1'b1;
    wb_bus[k].phys_rd = tag[PHYS_REG_IDX_W-1:0];
    wb_bus[k].result  = val;
  endtask

  // Fill 5 entries with issue stalled, then kill everything via flush or reset.
  task automatic run_kill(input bit use_rst);
    issue_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp_entry = mk(20 + i, 0, 40, 1, 41, 1);
      disp_valid = 1'b1;
      tick();
    end
    disp_valid = 1'b0;
    check_val("kill_pre_cnt", 64'(count), 64'd4);
    check_val("kill_pre_vld", 64'(issue_valid), 64'd1);
    disp_entry = mk(25, 0, 40, 1, 41, 1);
    disp_valid = 1'b1;
    if (use_rst) rst_n = 1'b0;
    else flush = 1'b1;
    tick();
    disp_valid = 1'b0;
    rst_n      = 1'b1;
    flush      = 1'b0;
    check_val(use_rst ? "rst_cnt" : "flush_cnt", 64'(count), 64'd0);
    check_val(use_rst ? "rst_vld" : "flush_vld", 64'(issue_valid), 64'd0);
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("kill_post_vld", 64'(issue_valid), 64'd0);
    end
  endtask

  // Scoreboard: every accepted issue must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && !flush && issue_valid && issue_ready) begin
      check_val("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check_val("sb_rob", 64'(issue_entry.rob_idx), 64'(mon_e.rob));
        check_val("sb_rs1_value", 64'(issue_entry.rs1_value), 64'(mon_e.v1));
        check_val("sb_rs2_value", 64'(issue_entry.rs2_value), 64'(mon_e.v2));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    rob_head    = '0;
    disp_valid  = 1'b0;
    disp_entry  = '0;
    wb_bus      = '0;
    fu_busy     = '0;
    issue_ready = 1'b0;
    tick();
    tick();
    check_val("rst_vld", 64'(issue_valid), 64'd0);
    check_val("rst_entry", 64'(issue_entry == '0), 64'd1);
    check_val("rst_cnt", 64'(count), 64'd0);
    rst_n = 1'b1;
    tick();
    check_val("rst_disp_rdy", 64'(disp_ready), 64'd1);

    // Basic two-cycle latency.
    issue_ready = 1'b1;
    push_exp(5, 32'h1005, 32'h2005);
    disp_entry = mk(5, 0, 40, 1, 41, 1);
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    check_val("t1_cnt_c1", 64'(count), 64'd1);
    check_val("t1_vld_c1", 64'(issue_valid), 64'd0);
    tick();
    check_val("t1_vld_c2", 64'(issue_valid), 64'd1);
    check_val("t1_rob_c2", 64'(issue_entry.rob_idx), 64'd5);
    check_val("t1_cnt_c2", 64'(count), 64'd0);
    tick();
    check_val("t1_vld_c3", 64'(issue_valid), 64'd0);

    // Wakeup: younger ready B goes first, A after broadcast of tag 12.
    push_exp(4, 32'h1004, 32'h2004);
    push_exp(3, 32'hDEAD, 32'h2003);
    disp_entry = mk(3, 1, 12, 0, 42, 1);
    disp_valid = 1'b1;
    tick();
    disp_entry = mk(4, 2, 43, 1, 44, 1);
    tick();
    disp_valid = 1'b0;
    check_val("t2_vld_c2", 64'(issue_valid), 64'd0);
    tick();
    check_val("t2_rob_b", 64'(issue_entry.rob_idx), 64'd4);
    set_wb(1, 12, 32'hDEAD);
    tick();
    wb_bus = '0;
    check_val("t2_vld_c4", 64'(issue_valid), 64'd0);
    tick();
    check_val("t2_vld_c5", 64'(issue_valid), 64'd1);
    check_val("t2_rob_a", 64'(issue_entry.rob_idx), 64'd3);
    check_val("t2_rs1_a", 64'(issue_entry.rs1_value), 64'hDEAD);
    tick();

    // Age wrap: head 30, rob 31 older than rob 1 despite higher slot.
    rob_head = 6'd30;
    fu_busy  = 8'h08;
    push_exp(31, 32'h101F, 32'h201F);
    push_exp(1, 32'h1001, 32'h2001);
    disp_entry = mk(1, 3, 40, 1, 41, 1);
    disp_valid = 1'b1;
    tick();
    disp_entry = mk(31, 3, 40, 1, 41, 1);
    tick();
    disp_valid = 1'b0;
    fu_busy    = '0;
    check_val("t3_busy_vld", 64'(issue_valid), 64'd0);
    tick();
    check_val("t3_first", 64'(issue_entry.rob_idx), 64'd31);
    tick();
    check_val("t3_second", 64'(issue_entry.rob_idx), 64'd1);
    tick();
    check_val("t3_idle", 64'(issue_valid), 64'd0);
    rob_head = '0;

    // Full queue, dropped dispatch, stall, then back-to-back drain.
    fu_busy     = '1;
    issue_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_exp(10 + i, 32'h1000 + 10 + i, 32'h2000 + 10 + i);
      disp_entry = mk(10 + i, 0, 40, 1, 41, 1);
      disp_valid = 1'b1;
      tick();
    end
    disp_valid = 1'b0;
    check_val("t4_full_cnt", 64'(count), 64'd8);
    check_val("t4_full_rdy", 64'(disp_ready), 64'd0);
    disp_entry = mk(60, 0, 40, 1, 41, 1);
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    check_val("t4_drop_cnt", 64'(count), 64'd8);
    fu_busy = '0;
    tick();
    check_val("t4_load_vld", 64'(issue_valid), 64'd1);
    check_val("t4_load_rob", 64'(issue_entry.rob_idx), 64'd10);
    check_val("t4_load_cnt", 64'(count), 64'd7);
    check_val("t4_load_rdy", 64'(disp_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t4_hold_rob", 64'(issue_entry.rob_idx), 64'd10);
      check_val("t4_hold_cnt", 64'(count), 64'd7);
    end
    issue_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check_val("t4_b2b_rob", 64'(issue_entry.rob_idx), 64'(10 + i));
    end
    tick();
    check_val("t4_drain_vld", 64'(issue_valid), 64'd0);
    check_val("t4_drain_cnt", 64'(count), 64'd0);

    // Same-cycle broadcast on dispatch; lowest port wins for rs1.
    push_exp(50, 32'h11, 32'h55);
    disp_entry = mk(50, 4, 9, 0, 7, 0);
    set_wb(0, 9, 32'h11);
    set_wb(1, 9, 32'h22);
    set_wb(2, 7, 32'h55);
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    wb_bus     = '0;
    check_val("t5_vld_c1", 64'(issue_valid), 64'd0);
    tick();
    check_val("t5_vld_c2", 64'(issue_valid), 64'd1);
    check_val("t5_rs2", 64'(issue_entry.rs2_value), 64'h55);
    check_val("t5_rs1", 64'(issue_entry.rs1_value), 64'h11);
    tick();

    // Flush and mid-run reset with a same-cycle dispatch.
    run_kill(1'b0);
    run_kill(1'b1);

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Unified issue queue controller for the out-of-order core. Sits between rename/dispatch and the functional units.
- Holds up to IQ_LENGTH iq_entry_t records and wakes operands from the writeback bypass broadcasts.
- Each cycle it selects the oldest ready entry, by ROB age, whose FU is not busy, and presents it on a registered valid/ready issue port.

Parameters:
- IQ_LENGTH, 8, queue slots (general_defines)
- BYPASS_LENGTH, 3, writeback broadcast ports (general_defines)
- NUM_FU_TYPES, 8, width of fu_busy_i; fu_type indexes it

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  clear all entries and the issue register
- rob_head_i  in  ROB_IDX_W+1  current ROB head, including the wrap bit
- disp_valid_i  in  1  dispatch request
- disp_entry_i  in  iq_entry_t  entry to insert; its valid field is ignored
- disp_ready_o  out  1  space available
- wb_bus_i  in  bypass_entry_t[BYPASS_LENGTH]  wakeup broadcasts
- fu_busy_i  in  NUM_FU_TYPES  FU cannot accept this cycle
- issue_valid_o  out  1  issue register holds an instruction
- issue_entry_o  out  iq_entry_t  instruction being issued; both operands ready and values valid
- issue_ready_i  in  1  FU accepts issue_entry_o
- count_o  out  IQ_IDX_W+1  occupied slots, excluding the issue register

Behaviour:
- Reset (rst_n=0 at posedge):
  - all slot valid bits = 0
  - issue_valid_o = 0
  - issue_entry_o = '0
  - count_o = 0
  - disp_ready_o = 1 in the first cycle after reset
- disp_ready_o = (count_o < IQ_LENGTH). It is derived from registered state only; a slot freed this cycle is not credited until the next cycle.
- Dispatch, when disp_valid_i && disp_ready_o:
  - entry is written into the lowest-index free slot with valid=1
  - its rs1/rs2 tags are compared against wb_bus_i in the same cycle; on a match the ready bit is set and the value captured on write, so a same-cycle broadcast is never missed
  - disp_valid_i && !disp_ready_o is dropped; upstream must hold it
- Wakeup: for every valid slot and every wb_bus_i[k].valid:
  - phys_rs1 == phys_rd && !rs1_ready -> rs1_ready=1, rs1_value=result (same for rs2)
  - multiple matching ports: lowest k wins
  - already-ready operands are never overwritten
- Selection (combinational on registered slot state):
  - candidate = valid && rs1_ready && rs2_ready && !fu_busy_i[fu_type]
  - fu_type >= NUM_FU_TYPES is never a candidate
  - age = (rob_idx - rob_head_i) mod 2^(ROB_IDX_W+1); smallest age wins; ties go to the lowest slot index
  - a wakeup in cycle N makes the entry a candidate in cycle N+1, not N
- Issue register:
  - loads when (!issue_valid_o || issue_ready_i) and a candidate exists: the winning slot moves into issue_entry_o and the slot is freed on the same edge
  - if no candidate and issue_ready_i: issue_valid_o -> 0
  - issue_valid_o && !issue_ready_i: issue_entry_o held stable, no selection
- Latency: operands ready at dispatch in cycle N -> issue_valid_o in cycle N+2, with an empty issue register and FU not busy. Back-to-back issue at 1/cycle with issue_ready_i held high.
- count_o next = count + dispatched - selected. Simultaneous dispatch and select when full is illegal by construction, since disp_ready_o=0.
- Flush:
  - flush_i=1 at posedge -> all slots invalid, issue_valid_o=0, count_o=0
  - flush overrides same-cycle dispatch, wakeup and select
  - issue_ready_i is ignored during flush
- Reset mid-operation: identical to power-on reset. rst_n overrides flush_i.
- Wakeup does not apply to issue_entry_o; it is always fully ready.

Decomposition:
- iq_entry_t, bypass_entry_t, IQ_IDX_W, ROB_IDX_W, PHYS_REG_IDX_W and NUM_FU_TYPES live in general_defines.
- One sub-module: iq_age_select. It is a combinational oldest-ready picker that takes a candidate mask, per-slot rob_idx and rob_head_i, and returns a one-hot grant plus an index.
- Wakeup, allocation and the issue register remain in issue_scheduler.

Test Plan:
- Dispatch rob_idx=5, both ready, fu_type=0, fu_busy_i=0, issue_ready_i=1 in cycle 0 -> issue_valid_o=1 in cycle 2 with rob_idx=5; count_o 1 -> 0.
- Dispatch A (rob 3, rs1 tag 12 not ready) then B (rob 4, ready); broadcast tag 12, result 0xDEAD in cycle 3 -> B issues first; A issues in cycle 5 with rs1_value=0xDEAD.
- rob_head_i=30 (wrap): slots hold rob_idx 31 and rob_idx 1, both ready -> 31 issues before 1.
- Fill 8 entries -> disp_ready_o=0 and count_o=8; hold issue_ready_i=0 -> issue_entry_o stable for 5 cycles; then one issue -> disp_ready_o=1 next cycle.
- Same-cycle dispatch with rs2 tag 7 and wb_bus_i[2]={1,7,0x55} -> entry issues with rs2_value=0x55 and no further broadcast needed.
- 4 entries live, issue_valid_o=1, assert flush_i together with disp_valid_i -> next cycle count_o=0 and issue_valid_o=0; the dispatched entry is never issued. Repeat with rst_n=0 instead of flush_i -> same result.
